// File: rtl/l2_request_ingress_pkg.sv
// l2_request_ingress_pkg: request packet type, default depth and a power-of-two helper
package l2_request_ingress_pkg;

    localparam int L2I_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  thread;
        logic [31:0] address;
        logic [31:0] data;
    } l2req_packet_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/l2_request_ingress_fifo.sv
// sync_fifo: registered-storage FIFO with full/empty/count, no bypass
module sync_fifo
    import l2_request_ingress_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(SIZE):0]  count
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [SIZE];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full    = count == CW'(SIZE);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];

    // storage write; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap modulo SIZE; occupancy kept in its own counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CW'(SIZE));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(rd_en && empty));
    a_size_pow2: assert property (@(posedge clk) is_pow2(SIZE));

endmodule

// File: rtl/l2_request_ingress.sv
// l2_request_ingress: per-core request buffer decoupling the core handshake from L2 backpressure
module l2_request_ingress
    import l2_request_ingress_pkg::*;
#(
    parameter int DEPTH = L2I_DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_request_valid,
    input  l2req_packet_t           core_request,
    output logic                    core_ready,
    output logic                    l2i_request_valid,
    output l2req_packet_t           l2i_request,
    input  logic                    l2_ready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    perf_ingress_stall
);
    localparam int W = $bits(l2req_packet_t);

    logic         full;
    logic         empty;
    logic [W-1:0] rd_data;
    logic         enq;
    logic         deq;

    // ready comes only from registered fullness, gated off while reset is held
    always_comb begin
        core_ready         = !full && !reset;
        l2i_request_valid  = !empty;
        l2i_request        = l2req_packet_t'(rd_data);
        enq                = core_request_valid && core_ready;
        deq                = l2i_request_valid && l2_ready;
        perf_ingress_stall = core_request_valid && !core_ready;
    end

    sync_fifo #(.WIDTH(W), .SIZE(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (enq),
        .wr_data (core_request),
        .rd_en   (deq),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (occupancy)
    );

endmodule

// File: tb/tb_l2_request_ingress.sv
// tb_l2_request_ingress: scoreboard bench for the L2 request ingress buffer
module tb_l2_request_ingress;
    import l2_request_ingress_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 0;
    logic          reset = 1;
    logic          core_request_valid = 0;
    l2req_packet_t core_request = '0;
    logic          core_ready;
    logic          l2i_request_valid;
    l2req_packet_t l2i_request;
    logic          l2_ready = 0;
    logic [2:0]    occupancy;
    logic          perf_ingress_stall;

    int total = 0;
    int bad = 0;
    int m_occ = 0;
    l2req_packet_t sb[$];

    l2_request_ingress #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .core_request_valid (core_request_valid),
        .core_request       (core_request),
        .core_ready         (core_ready),
        .l2i_request_valid  (l2i_request_valid),
        .l2i_request        (l2i_request),
        .l2_ready           (l2_ready),
        .occupancy          (occupancy),
        .perf_ingress_stall (perf_ingress_stall)
    );

    always #5 clk = ~clk;

    function automatic l2req_packet_t mk(input logic [31:0] a);
        l2req_packet_t p;
        p.opcode  = a[4:2];
        p.thread  = a[7:6];
        p.address = a;
        p.data    = ~a ^ 32'h5A5A_0000;
        return p;
    endfunction

    // dequeue monitor: every accepted head must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && l2i_request_valid && l2_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL deq_unexpected: got addr=%h, required no dequeue", l2i_request.address);
            end else begin
                l2req_packet_t e;
                e = sb.pop_front();
                if (l2i_request !== e) begin
                    bad++;
                    $display("FAIL deq_order: got %h, required %h", l2i_request, e);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] a, input bit r);
        bit acc;
        bit deq;
        core_request_valid = v;
        core_request = mk(a);
        l2_ready = r;
        acc = v && (m_occ != DEPTH);
        deq = (m_occ != 0) && r;
        if (acc) sb.push_back(mk(a));
        @(posedge clk);
        #1;
        m_occ = m_occ + int'(acc) - int'(deq);
    endtask

    task automatic test_reset();
        reset = 1;
        core_request_valid = 1;
        @(posedge clk);
        #1;
        total++;
        if (core_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_forced: got %b, required 0", core_ready); end
        core_request_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        total++;
        if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ: got %0d, required 0", occupancy); end
        total++;
        if (l2i_request_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", l2i_request_valid); end
        total++;
        if (core_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", core_ready); end
        total++;
        if (perf_ingress_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b, required 0", perf_ingress_stall); end
    endtask

    task automatic test_single();
        drive(1, 32'h1000, 1);
        total++;
        if (l2i_request_valid !== 1'b1 || l2i_request.address !== 32'h1000) begin
            bad++; $display("FAIL single_latency: got valid=%b addr=%h, required 1 1000", l2i_request_valid, l2i_request.address);
        end
        total++;
        if (occupancy !== 3'd1) begin bad++; $display("FAIL single_occ1: got %0d, required 1", occupancy); end
        drive(0, 0, 1);
        total++;
        if (occupancy !== 3'd0 || l2i_request_valid !== 1'b0) begin
            bad++; $display("FAIL single_occ0: got occ=%0d valid=%b, required 0 0", occupancy, l2i_request_valid);
        end
    endtask

    task automatic test_fill_full();
        logic [31:0] addrs [4] = '{32'h40, 32'h80, 32'hC0, 32'h100};
        for (int i = 0; i < 4; i++) begin
            drive(1, addrs[i], 0);
            total++;
            if (occupancy !== 3'(i + 1)) begin bad++; $display("FAIL fill_occ: got %0d, required %0d", occupancy, i + 1); end
            total++;
            if (core_ready !== (i < 3)) begin bad++; $display("FAIL fill_ready: got %b, required %b", core_ready, i < 3); end
        end
        core_request_valid = 1;
        core_request = mk(32'h140);
        #1;
        total++;
        if (perf_ingress_stall !== 1'b1) begin bad++; $display("FAIL fill_stall: got %b, required 1", perf_ingress_stall); end
        drive(1, 32'h140, 0);
        total++;
        if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ_full: got %0d, required 4", occupancy); end
    endtask

    task automatic test_full_deq();
        drive(1, 32'h180, 1);
        total++;
        if (occupancy !== 3'd3) begin bad++; $display("FAIL fulldeq_occ: got %0d, required 3", occupancy); end
        total++;
        if (core_ready !== 1'b1) begin bad++; $display("FAIL fulldeq_ready: got %b, required 1", core_ready); end
        for (int i = 0; i < 3; i++) drive(0, 0, 1);
        total++;
        if (occupancy !== 3'd0 || l2i_request_valid !== 1'b0) begin
            bad++; $display("FAIL fulldeq_drain: got occ=%0d valid=%b, required 0 0", occupancy, l2i_request_valid);
        end
    endtask

    task automatic test_stream_wrap();
        int i = 0;
        int c = 0;
        while (i < 12 && c < 100) begin
            if (m_occ != DEPTH) begin
                drive(1, 32'h2000 + 32'(i) * 4, (c % 2) == 0);
                i++;
            end else begin
                drive(0, 0, (c % 2) == 0);
            end
            total++;
            if (occupancy !== 3'(m_occ)) begin bad++; $display("FAIL stream_occ: got %0d, required %0d", occupancy, m_occ); end
            c++;
        end
        for (int k = 0; k < 20 && m_occ != 0; k++) drive(0, 0, 1);
        total++;
        if (i != 12 || sb.size() != 0 || occupancy !== 3'd0) begin
            bad++; $display("FAIL stream_done: got sent=%0d left=%0d occ=%0d, required 12 0 0", i, sb.size(), occupancy);
        end
    endtask

    task automatic test_hold();
        l2req_packet_t p;
        drive(1, 32'h3000, 0);
        drive(1, 32'h3004, 0);
        p = mk(32'h3000);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0);
            total++;
            if (l2i_request !== p || l2i_request_valid !== 1'b1) begin
                bad++; $display("FAIL hold_stable: got %h valid=%b, required %h", l2i_request, l2i_request_valid, p);
            end
        end
        drive(0, 0, 1);
        drive(0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) drive(1, 32'h4000 + 32'(k) * 4, 0);
        total++;
        if (occupancy !== 3'd3) begin bad++; $display("FAIL midrst_pre: got %0d, required 3", occupancy); end
        reset = 1;
        core_request_valid = 1;
        core_request = mk(32'h4FFC);
        l2_ready = 0;
        #1;
        total++;
        if (core_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_forced: got %b, required 0", core_ready); end
        @(posedge clk);
        #1;
        reset = 0;
        core_request_valid = 0;
        sb.delete();
        m_occ = 0;
        #1;
        total++;
        if (l2i_request_valid !== 1'b0 || occupancy !== 3'd0 || core_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_post: got valid=%b occ=%0d ready=%b, required 0 0 1", l2i_request_valid, occupancy, core_ready);
        end
        drive(1, 32'h5000, 1);
        drive(0, 0, 1);
        total++;
        if (sb.size() != 0 || occupancy !== 3'd0) begin
            bad++; $display("FAIL midrst_after: got left=%0d occ=%0d, required 0 0", sb.size(), occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_full_deq();
        test_stream_wrap();
        test_hold();
        test_reset_mid();
        drive(0, 0, 0);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_empty: got %0d left, required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
